// File: rtl/spi_flash_pkg.sv
// ----------------------------------------------------------------------------
// spi_flash_pkg
//  Shared constants and the controller state type for the single-I/O SPI
//  flash reader.
//   FLASH_CMD_READ : opcode of the plain (non-fast) flash read command
//   CMD_BITS       : opcode length on the wire
//   ADDR_BITS      : address length on the wire
//   BYTE_BITS      : bits per received data byte
//   state_t        : controller states
// ----------------------------------------------------------------------------
package spi_flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         CMD_BITS       = 8;
    localparam int         ADDR_BITS      = 24;
    localparam int         BYTE_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// ----------------------------------------------------------------------------
// spi_sck_gen
//  Mode-0 SCK generator. While enable is high, sck toggles every CLK_DIV
//  clocks, starting with a full low phase. While enable is low, sck is parked
//  low and the phase counter is cleared, so re-enabling always begins with a
//  complete low phase.
//  Ports:
//   clock  in  system clock
//   resetb in  synchronous active-low reset
//   enable in  run the divider
//   sck    out SCK level (registered)
//   rise   out high in the cycle whose closing edge drives sck 0->1
//   fall   out high in the cycle whose closing edge drives sck 1->0
// ----------------------------------------------------------------------------
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic enable,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] half_cnt;
    logic          phase_end;

    // The strobes announce the edge that the register below is about to make,
    // letting the parent update io0/rx on exactly the same clock edge.
    assign phase_end = enable && (half_cnt == LAST);
    assign rise      = phase_end && !sck;
    assign fall      = phase_end && sck;

    // Half-period divider: counts CLK_DIV clocks per SCK phase, then toggles.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (!enable) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (phase_end) begin
            half_cnt <= '0;
            sck      <= ~sck;
        end else begin
            half_cnt <= half_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// ----------------------------------------------------------------------------
// spi_flash_reader
//  SPI master for single-I/O flash reads (opcode 0x03). A request of
//  (address, length) is turned into one chip-select window: opcode, 24-bit
//  address, then `length` data bytes streamed out on a valid/ready port.
//  Between bytes SCK is parked low with CSB still low, so a stalled consumer
//  simply pauses the read without restarting it.
//  Ports:
//   clock, resetb        system clock, synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_addr, req_len    flash byte address and byte count (0 = no access)
//   rd_valid/rd_ready    received-byte handshake
//   rd_data, rd_last     received byte (MSB first on wire), final-byte flag
//   done, busy           completion pulse, request-in-progress level
//   flash_csb/clk/io0    chip select (active low), SCK (mode 0), MOSI
//   flash_io1            MISO
// ----------------------------------------------------------------------------
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CSB_IDLE = 4,
    parameter int LEN_W    = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             done,
    output logic             busy,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic             flash_io0,
    input  logic             flash_io1
);

    localparam int GW = $clog2(CSB_IDLE + 1);

    state_t           state;
    logic [31:0]      tx_shift;
    logic [7:0]       rx_shift;
    logic [4:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             sck_run;
    logic             sck_rise;
    logic             sck_fall;

    assign req_ready = (state == IDLE);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clock  (clock),
        .resetb (resetb),
        .enable (sck_run),
        .sck    (flash_clk),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    // Main controller. The accept edge only latches the request; CSB falls
    // on the following edge together with the opcode MSB on io0 and the start
    // of SCK. From then on io0 moves only on SCK falls and io1 is captured on
    // SCK rises. A byte is handed over on the fall that ends its 8th bit, so
    // SCK is already low when it parks for the HOLD state.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state     <= IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            sck_run   <= 1'b0;
            flash_csb <= 1'b1;
            flash_io0 <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (sck_rise) begin
                rx_shift <= {rx_shift[6:0], flash_io1};
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        busy     <= 1'b1;
                        tx_shift <= {FLASH_CMD_READ, req_addr};
                        byte_cnt <= req_len;
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
                        state    <= (req_len == '0) ? GAP : CMD;
                    end
                end

                CMD: begin
                    if (flash_csb) begin
                        flash_csb <= 1'b0;
                        flash_io0 <= tx_shift[31];
                        sck_run   <= 1'b1;
                    end else if (sck_fall) begin
                        flash_io0 <= tx_shift[30];
                        tx_shift  <= {tx_shift[30:0], 1'b0};
                        if (bit_cnt == 5'(CMD_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= ADDR;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                // The shift register empties to zero, so io0 reads 0 from the
                // last address fall onwards.
                ADDR: begin
                    if (sck_fall) begin
                        flash_io0 <= tx_shift[30];
                        tx_shift  <= {tx_shift[30:0], 1'b0};
                        if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                DATA: begin
                    flash_io0 <= 1'b0;
                    if (sck_fall) begin
                        if (bit_cnt == 5'(BYTE_BITS - 1)) begin
                            rd_data  <= rx_shift;
                            rd_valid <= 1'b1;
                            rd_last  <= (byte_cnt == LEN_W'(1));
                            sck_run  <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                // byte_cnt still includes the byte on offer, so a count of one
                // means this handshake ends the request.
                HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        byte_cnt <= byte_cnt - LEN_W'(1);
                        if (byte_cnt != LEN_W'(1)) begin
                            sck_run <= 1'b1;
                            state   <= DATA;
                        end else begin
                            flash_csb <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GW'(CSB_IDLE - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_reader
//  Directed bench for spi_flash_reader with a small behavioural SPI flash
//  (256-byte image, address wraps inside the image) responding on io1.
// ----------------------------------------------------------------------------
module tb_spi_flash_reader;

    localparam int CLK_DIV  = 2;
    localparam int CSB_IDLE = 4;
    localparam int LEN_W    = 16;
    localparam int READ_LAT = 1 + 80 * CLK_DIV;

    logic             clock = 1'b0;
    logic             resetb;
    logic             req_valid;
    logic             req_ready;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             rd_valid;
    logic             rd_ready;
    logic [7:0]       rd_data;
    logic             rd_last;
    logic             done;
    logic             busy;
    logic             flash_csb;
    logic             flash_clk;
    logic             flash_io0;
    logic             flash_io1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    spi_flash_reader #(
        .CLK_DIV  (CLK_DIV),
        .CSB_IDLE (CSB_IDLE),
        .LEN_W    (LEN_W)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .busy      (busy),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1)
    );

    // Flash model: shifts in opcode+address on SCK rises, then presents the
    // addressed bytes MSB first, advancing one bit per rise.
    logic [7:0]  mem [256];
    int          mdl_bits = 0;
    logic [31:0] mdl_in   = '0;
    logic [31:0] mdl_hdr  = '0;
    int          mdl_rel;
    int          sck_rises = 0;

    always @(posedge flash_clk or posedge flash_csb) begin
        if (flash_csb) begin
            mdl_bits <= 0;
            mdl_in   <= '0;
        end else begin
            if (mdl_bits < 32) mdl_in <= {mdl_in[30:0], flash_io0};
            if (mdl_bits == 31) mdl_hdr <= {mdl_in[30:0], flash_io0};
            mdl_bits <= mdl_bits + 1;
        end
    end

    always @(posedge flash_clk) sck_rises <= sck_rises + 1;

    always_comb begin
        flash_io1 = 1'b0;
        mdl_rel   = mdl_bits - 32;
        if (!flash_csb && mdl_bits >= 32)
            flash_io1 = mem[8'(mdl_hdr[7:0] + 8'(mdl_rel / 8))][7 - (mdl_rel % 8)];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one request; returns at the negedge just after the accept edge.
    task automatic applyStimulus(input logic [23:0] addr, input logic [LEN_W-1:0] len);
        @(negedge clock);
        checkOutput("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic waitValid(output int k);
        k = 0;
        while (!rd_valid && k < 2000) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic acceptByte();
        rd_ready = 1'b1;
        @(negedge clock);
        rd_ready = 1'b0;
    endtask

    task automatic waitDone(output int k);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clock);
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  k;
        int  rises0;
        logic stable;
        logic csb_ok;
        logic done_seen;
        logic [7:0] first;

        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37) ^ 8'hA5);

        resetb    = 1'b0;
        req_valid = 1'b0;
        rd_ready  = 1'b0;
        req_addr  = '0;
        req_len   = '0;

        // 1. reset and idle
        repeat (5) @(negedge clock);
        checkOutput("rst_csb",     32'(flash_csb), 32'd1);
        checkOutput("rst_clk",     32'(flash_clk), 32'd0);
        checkOutput("rst_io0",     32'(flash_io0), 32'd0);
        checkOutput("rst_rd_valid",32'(rd_valid),  32'd0);
        checkOutput("rst_rd_last", 32'(rd_last),   32'd0);
        checkOutput("rst_rd_data", 32'(rd_data),   32'd0);
        checkOutput("rst_done",    32'(done),      32'd0);
        checkOutput("rst_busy",    32'(busy),      32'd0);
        resetb = 1'b1;
        @(negedge clock);
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
        rises0 = sck_rises;
        repeat (10) @(negedge clock);
        checkOutput("idle_no_sck", 32'(sck_rises), 32'(rises0));
        checkOutput("idle_csb",    32'(flash_csb), 32'd1);

        // 2. single byte read
        $display("[TB] single read at 0x000010");
        applyStimulus(24'h000010, 16'd1);
        checkOutput("t2_busy", 32'(busy), 32'd1);
        waitValid(k);
        checkOutput("t2_latency",  32'(k),         32'(READ_LAT));
        checkOutput("t2_rd_valid", 32'(rd_valid),  32'd1);
        checkOutput("t2_rd_data",  32'(rd_data),   32'(mem[8'h10]));
        checkOutput("t2_rd_last",  32'(rd_last),   32'd1);
        checkOutput("t2_wire_hdr", mdl_hdr,        32'h03000010);
        checkOutput("t2_csb_low",  32'(flash_csb), 32'd0);
        checkOutput("t2_sck_park", 32'(flash_clk), 32'd0);
        acceptByte();
        checkOutput("t2_csb_rise", 32'(flash_csb), 32'd1);
        checkOutput("t2_rd_valid_drop", 32'(rd_valid), 32'd0);
        waitDone(k);
        checkOutput("t2_done_delay", 32'(k),         32'(CSB_IDLE));
        checkOutput("t2_done_busy",  32'(busy),      32'd0);
        checkOutput("t2_done_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        checkOutput("t2_done_pulse", 32'(done), 32'd0);

        // 3. burst with backpressure
        $display("[TB] burst of 4 with stalls");
        applyStimulus(24'h000000, 16'd4);
        for (int i = 0; i < 4; i++) begin
            waitValid(k);
            checkOutput("t3_rd_valid", 32'(rd_valid), 32'd1);
            first  = rd_data;
            stable = 1'b1;
            repeat (20) begin
                @(negedge clock);
                if (rd_data !== first || rd_valid !== 1'b1 || flash_clk !== 1'b0 ||
                    flash_csb !== 1'b0 || rd_last !== (i == 3))
                    stable = 1'b0;
            end
            checkOutput("t3_stall_stable", 32'(stable),  32'd1);
            checkOutput("t3_rd_data",      32'(rd_data), 32'(mem[i]));
            checkOutput("t3_rd_last",      32'(rd_last), 32'(i == 3));
            acceptByte();
        end
        waitDone(k);
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);

        // 4. zero length
        $display("[TB] zero-length request");
        rises0 = sck_rises;
        applyStimulus(24'h000055, 16'd0);
        checkOutput("t4_busy", 32'(busy), 32'd1);
        csb_ok = 1'b1;
        k = 0;
        while (!done && k < 200) begin
            if (flash_csb !== 1'b1) csb_ok = 1'b0;
            @(negedge clock);
            k++;
        end
        checkOutput("t4_done_delay", 32'(k),         32'(CSB_IDLE));
        checkOutput("t4_csb_high",   32'(csb_ok),    32'd1);
        checkOutput("t4_no_sck",     32'(sck_rises), 32'(rises0));
        checkOutput("t4_busy_drop",  32'(busy),      32'd0);
        checkOutput("t4_ready",      32'(req_ready), 32'd1);

        // 5. reset during the 10th address bit
        $display("[TB] reset mid-address");
        applyStimulus(24'h000040, 16'd3);
        k = 0;
        while (mdl_bits != 17 && k < 500) begin
            @(negedge clock);
            k++;
        end
        checkOutput("t5_reached_bit", 32'(mdl_bits), 32'd17);
        resetb = 1'b0;
        @(negedge clock);
        checkOutput("t5_csb",  32'(flash_csb), 32'd1);
        checkOutput("t5_clk",  32'(flash_clk), 32'd0);
        checkOutput("t5_busy", 32'(busy),      32'd0);
        done_seen = 1'b0;
        repeat (3) begin
            if (done) done_seen = 1'b1;
            @(negedge clock);
        end
        resetb = 1'b1;
        repeat (10) begin
            if (done) done_seen = 1'b1;
            @(negedge clock);
        end
        checkOutput("t5_no_done", 32'(done_seen), 32'd0);
        applyStimulus(24'h000020, 16'd2);
        for (int i = 0; i < 2; i++) begin
            waitValid(k);
            checkOutput("t5_rd_data", 32'(rd_data), 32'(mem[8'h20 + i]));
            checkOutput("t5_rd_last", 32'(rd_last), 32'(i == 1));
            acceptByte();
        end
        waitDone(k);
        checkOutput("t5_done",     32'(done), 32'd1);
        checkOutput("t5_wire_hdr", mdl_hdr,   32'h03000020);

        // 6. request during DATA is ignored
        $display("[TB] ignored request during data");
        applyStimulus(24'h000030, 16'd2);
        k = 0;
        while (mdl_bits < 34 && k < 500) begin
            @(negedge clock);
            k++;
        end
        checkOutput("t6_in_data_ready", 32'(req_ready), 32'd0);
        req_addr  = 24'h000050;
        req_len   = 16'd1;
        req_valid = 1'b1;
        repeat (3) @(negedge clock);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            waitValid(k);
            checkOutput("t6_rd_data", 32'(rd_data), 32'(mem[8'h30 + i]));
            checkOutput("t6_rd_last", 32'(rd_last), 32'(i == 1));
            acceptByte();
        end
        waitDone(k);
        checkOutput("t6_done",     32'(done), 32'd1);
        checkOutput("t6_wire_hdr", mdl_hdr,   32'h03000030);
        rises0 = sck_rises;
        repeat (10) @(negedge clock);
        checkOutput("t6_no_restart_sck", 32'(sck_rises), 32'(rises0));
        checkOutput("t6_no_restart_csb", 32'(flash_csb), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
